// File: rtl/sort_pkg.sv
// Shared types, default sizes and the wrap-safe due-time test for the
// sort eject scheduler.
package sort_pkg;

    localparam int DELAY_W_DEF = 24;
    localparam int WIDTH_W_DEF = 16;
    localparam int DEPTH_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FIRE = 2'd2
    } sched_state_t;

    // The due time counts as reached when (ts - due) mod 2^w has a clear MSB.
    // This stays correct across counter wrap, provided due is never more
    // than half the counter range ahead of ts.
    function automatic logic due_reached(input logic [63:0] ts,
                                         input logic [63:0] due,
                                         input int          w);
        logic [63:0] diff;
        diff = ts - due;
        return ~diff[w-1];
    endfunction

endpackage

// File: rtl/sort_eject_scheduler_if.sv
// Control, configuration and status bundle of the sort eject scheduler.
// The master side drives detector level and configuration; the slave side
// is the scheduler itself.
interface sort_eject_scheduler_if
    import sort_pkg::*;
#(
    parameter int DELAY_W = DELAY_W_DEF,
    parameter int WIDTH_W = WIDTH_W_DEF,
    parameter int DEPTH   = DEPTH_DEF
);
    logic                     enable;
    logic                     det_in;
    logic [DELAY_W-1:0]       cfg_delay;
    logic [WIDTH_W-1:0]       cfg_pulse_width;
    logic [WIDTH_W-1:0]       cfg_holdoff;
    logic                     clr_sticky;
    logic                     eject_out;
    logic                     busy;
    logic [$clog2(DEPTH):0]   queue_count;
    logic                     overflow_sticky;
    logic                     late_sticky;

    modport master (
        output enable, det_in, cfg_delay, cfg_pulse_width, cfg_holdoff, clr_sticky,
        input  eject_out, busy, queue_count, overflow_sticky, late_sticky
    );

    modport slave (
        input  enable, det_in, cfg_delay, cfg_pulse_width, cfg_holdoff, clr_sticky,
        output eject_out, busy, queue_count, overflow_sticky, late_sticky
    );

endinterface

// File: rtl/sort_event_fifo.sv
// Pending-event queue of due timestamps. First-word-fall-through head,
// pointer-plus-wrap-bit full/empty, and a flush that empties it in one cycle.
// A push into a full queue succeeds when a pop happens in the same cycle.
module sort_event_fifo
    import sort_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DELAY_W_DEF
) (
    input  logic                    clk_100m,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [DATA_W-1:0]       din,
    output logic [DATA_W-1:0]       dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Advance pointers; flush empties the queue and overrides push/pop.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values, independent of block evaluation order.
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Store pushed due times.
    always_ff @(posedge clk_100m) begin
        // NOTE: storage is deliberately not reset; the pointers define which
        // entries are valid, and an unreset array maps onto plain RAM.
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/sort_eject_scheduler.sv
// Turns detector rising edges into delayed, fixed-width ejector pulses.
// Each accepted edge queues due = ts + min(cfg_delay, 2^(DELAY_W-1)-1),
// computed on the cycle after acceptance; a three-state FSM fires the queue
// head once its due time is reached.
module sort_eject_scheduler
    import sort_pkg::*;
#(
    parameter int DELAY_W = DELAY_W_DEF,
    parameter int WIDTH_W = WIDTH_W_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic                     clk_100m,
    input  logic                     rst_n,
    sort_eject_scheduler_if.slave    bus
);
    localparam logic [DELAY_W-1:0] MAX_DELAY = {1'b0, {(DELAY_W-1){1'b1}}};

    logic [DELAY_W-1:0]      ts;
    logic [DELAY_W-1:0]      eff_delay;
    logic [DELAY_W-1:0]      head_due;
    logic                    det_d;
    logic                    det_edge;
    logic                    accept;
    logic                    push_req;
    logic [WIDTH_W-1:0]      holdoff_cnt;
    logic [WIDTH_W-1:0]      width_cnt;
    sched_state_t            state;
    logic                    wait_first;
    logic                    reached;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    overflow_set;
    logic                    late_set;
    logic                    eject_q;
    logic                    overflow_q;
    logic                    late_q;

    assign det_edge  = bus.det_in & ~det_d;
    assign accept    = det_edge & bus.enable & (holdoff_cnt == '0);
    assign eff_delay = (bus.cfg_delay > MAX_DELAY) ? MAX_DELAY : bus.cfg_delay;
    assign reached   = due_reached(64'(ts), 64'(head_due), DELAY_W);

    assign fifo_pop     = bus.enable && (state == WAIT) && !fifo_empty && reached;
    assign overflow_set = bus.enable && push_req && fifo_full && !fifo_pop;
    assign late_set     = fifo_pop && wait_first && (ts != head_due);

    sort_event_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DELAY_W)
    ) u_fifo (
        .clk_100m (clk_100m),
        .rst_n    (rst_n),
        .push     (push_req),
        .pop      (fifo_pop),
        .flush    (!bus.enable),
        .din      (ts + eff_delay),
        .dout     (head_due),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Free-running timestamp, wraps mod 2^DELAY_W and ignores enable.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) ts <= '0;
        else        ts <= ts + DELAY_W'(1);
    end

    // Edge detect history, holdoff window and the one-cycle push request.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            det_d       <= 1'b0;
            holdoff_cnt <= '0;
            push_req    <= 1'b0;
        end else begin
            det_d    <= bus.det_in;
            push_req <= accept;
            if (!bus.enable)              holdoff_cnt <= '0;
            else if (accept)              holdoff_cnt <= bus.cfg_holdoff;
            else if (holdoff_cnt != '0)   holdoff_cnt <= holdoff_cnt - WIDTH_W'(1);
        end
    end

    // Firing FSM with registered eject output; disable aborts to IDLE.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            eject_q    <= 1'b0;
            width_cnt  <= '0;
            wait_first <= 1'b0;
        end else if (!bus.enable) begin
            state      <= IDLE;
            eject_q    <= 1'b0;
            width_cnt  <= '0;
            wait_first <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state      <= WAIT;
                        wait_first <= 1'b1;
                    end
                end
                WAIT: begin
                    wait_first <= 1'b0;
                    if (fifo_pop) begin
                        state     <= FIRE;
                        eject_q   <= 1'b1;
                        width_cnt <= (bus.cfg_pulse_width == '0) ? WIDTH_W'(1)
                                                                 : bus.cfg_pulse_width;
                    end
                end
                FIRE: begin
                    if (width_cnt <= WIDTH_W'(1)) begin
                        state   <= IDLE;
                        eject_q <= 1'b0;
                    end else begin
                        width_cnt <= width_cnt - WIDTH_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    eject_q <= 1'b0;
                end
            endcase
        end
    end

    // Sticky status; a same-cycle set beats clr_sticky.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            late_q     <= 1'b0;
        end else begin
            if (overflow_set)        overflow_q <= 1'b1;
            else if (bus.clr_sticky) overflow_q <= 1'b0;
            if (late_set)            late_q <= 1'b1;
            else if (bus.clr_sticky) late_q <= 1'b0;
        end
    end

    assign bus.eject_out       = eject_q;
    assign bus.busy            = (state != IDLE) || !fifo_empty;
    assign bus.queue_count     = fifo_count;
    assign bus.overflow_sticky = overflow_q;
    assign bus.late_sticky     = late_q;

endmodule

// File: tb/tb_sort_eject_scheduler.sv
// Directed bench for sort_eject_scheduler: a 24-bit timestamp instance for
// timing, holdoff, overflow, late and abort cases, plus an 8-bit instance
// for wrap and delay clamping. cyc restarts with reset, so at a falling
// edge cyc equals the ts value the next rising edge samples.
module tb_sort_eject_scheduler;

    logic clk_100m = 1'b0;
    logic rst_n;
    int   cyc;
    int   vectors = 0;
    int   miscompares = 0;

    int   rise24[$];
    int   fall24[$];
    int   rise8[$];
    int   fall8[$];
    logic ej24_prev = 1'b0;
    logic ej8_prev  = 1'b0;

    always #5 clk_100m = ~clk_100m;

    always @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    sort_eject_scheduler_if #(.DELAY_W(24), .WIDTH_W(16), .DEPTH(8)) bus24 ();
    sort_eject_scheduler_if #(.DELAY_W(8),  .WIDTH_W(16), .DEPTH(8)) bus8 ();

    sort_eject_scheduler #(.DELAY_W(24), .WIDTH_W(16), .DEPTH(8)) u_dut (
        .clk_100m (clk_100m),
        .rst_n    (rst_n),
        .bus      (bus24.slave)
    );

    sort_eject_scheduler #(.DELAY_W(8), .WIDTH_W(16), .DEPTH(8)) u_dut8 (
        .clk_100m (clk_100m),
        .rst_n    (rst_n),
        .bus      (bus8.slave)
    );

    // Record the first sampling edge of every rise and fall of eject_out.
    always @(negedge clk_100m) begin
        if (bus24.eject_out && !ej24_prev) rise24.push_back(cyc);
        if (!bus24.eject_out && ej24_prev) fall24.push_back(cyc);
        ej24_prev = bus24.eject_out;
        if (bus8.eject_out && !ej8_prev) rise8.push_back(cyc);
        if (!bus8.eject_out && ej8_prev) fall8.push_back(cyc);
        ej8_prev = bus8.eject_out;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk_100m);
    endtask

    task automatic pulse_det24(input int at);
        wait_cyc(at);
        bus24.det_in = 1'b1;
        @(negedge clk_100m);
        bus24.det_in = 1'b0;
    endtask

    task automatic pulse_det8(input int at);
        wait_cyc(at);
        bus8.det_in = 1'b1;
        @(negedge clk_100m);
        bus8.det_in = 1'b0;
    endtask

    task automatic pulse_clr24();
        bus24.clr_sticky = 1'b1;
        @(negedge clk_100m);
        bus24.clr_sticky = 1'b0;
    endtask

    task automatic clear_log();
        rise24.delete();
        fall24.delete();
        rise8.delete();
        fall8.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        bus24.enable = 1'b0; bus24.det_in = 1'b0; bus24.clr_sticky = 1'b0;
        bus24.cfg_delay = 24'd100; bus24.cfg_pulse_width = 16'd10; bus24.cfg_holdoff = 16'd0;
        bus8.enable = 1'b0; bus8.det_in = 1'b0; bus8.clr_sticky = 1'b0;
        bus8.cfg_delay = 8'd100; bus8.cfg_pulse_width = 16'd4; bus8.cfg_holdoff = 16'd0;

        // Reset state
        repeat (3) @(negedge clk_100m);
        check("rst_eject", bus24.eject_out, 0);
        check("rst_busy", bus24.busy, 0);
        check("rst_count", bus24.queue_count, 0);
        check("rst_ovf", bus24.overflow_sticky, 0);
        check("rst_late", bus24.late_sticky, 0);
        check("rst_eject8", bus8.eject_out, 0);
        rst_n = 1'b1;
        bus24.enable = 1'b1;
        bus8.enable  = 1'b1;

        // Single event: detect at edge 50, delay 100, width 10 -> high at 152..161
        pulse_det24(50);
        wait_cyc(60);
        check("single_count", bus24.queue_count, 1);
        check("single_busy", bus24.busy, 1);
        wait_cyc(170);
        check("single_n", rise24.size(), 1);
        check("single_rise", rise24[0], 152);
        check("single_fall", fall24[0], 162);
        check("single_late", bus24.late_sticky, 0);
        check("single_idle", bus24.busy, 0);

        // Holdoff 20: edges at 200, 210, 225 -> 210 ignored, pulses 25 apart
        clear_log();
        bus24.cfg_holdoff = 16'd20;
        bus24.cfg_pulse_width = 16'd5;
        pulse_det24(200);
        pulse_det24(210);
        wait_cyc(213);
        check("hold_count1", bus24.queue_count, 1);
        pulse_det24(225);
        wait_cyc(228);
        check("hold_count2", bus24.queue_count, 2);
        wait_cyc(340);
        check("hold_n", rise24.size(), 2);
        check("hold_rise0", rise24[0], 302);
        check("hold_rise1", rise24[1], 327);
        check("hold_fall0", fall24[0], 307);

        // Overflow: 9 edges 4 apart, delay 1000 -> 8 queued, flag, 8 pulses
        clear_log();
        bus24.cfg_holdoff = 16'd0;
        bus24.cfg_delay = 24'd1000;
        bus24.cfg_pulse_width = 16'd2;
        for (int k = 0; k < 9; k++) pulse_det24(400 + 4 * k);
        wait_cyc(436);
        check("ovf_count", bus24.queue_count, 8);
        check("ovf_flag", bus24.overflow_sticky, 1);
        pulse_clr24();
        check("ovf_clr", bus24.overflow_sticky, 0);
        check("ovf_count_kept", bus24.queue_count, 8);
        wait_cyc(1450);
        check("ovf_n", rise24.size(), 8);
        check("ovf_rise0", rise24[0], 1402);
        check("ovf_rise7", rise24[7], 1430);
        check("ovf_late", bus24.late_sticky, 0);
        check("ovf_empty", bus24.queue_count, 0);

        // Late fire: delay 50, width 30, edges 5 apart -> second pulse 2 low cycles later
        clear_log();
        bus24.cfg_delay = 24'd50;
        bus24.cfg_pulse_width = 16'd30;
        pulse_det24(1500);
        pulse_det24(1505);
        wait_cyc(1560);
        check("late_first_ok", bus24.late_sticky, 0);
        wait_cyc(1600);
        check("late_n", rise24.size(), 2);
        check("late_rise0", rise24[0], 1552);
        check("late_fall0", fall24[0], 1582);
        check("late_rise1", rise24[1], 1584);
        check("late_flag", bus24.late_sticky, 1);

        // Abort: enable low mid-FIRE with 3 queued
        clear_log();
        bus24.cfg_delay = 24'd30;
        bus24.cfg_pulse_width = 16'd40;
        pulse_det24(1700);
        pulse_det24(1703);
        pulse_det24(1706);
        pulse_det24(1709);
        wait_cyc(1740);
        check("abort_pre_eject", bus24.eject_out, 1);
        check("abort_pre_count", bus24.queue_count, 3);
        check("abort_pre_busy", bus24.busy, 1);
        bus24.enable = 1'b0;
        @(negedge clk_100m);
        check("abort_eject", bus24.eject_out, 0);
        check("abort_count", bus24.queue_count, 0);
        check("abort_busy", bus24.busy, 0);
        check("abort_late_held", bus24.late_sticky, 1);
        pulse_det24(1745);
        wait_cyc(1748);
        check("disabled_count", bus24.queue_count, 0);
        pulse_clr24();
        check("late_clr", bus24.late_sticky, 0);
        bus24.enable = 1'b1;

        // Zero width is stretched to a single cycle
        clear_log();
        bus24.cfg_delay = 24'd10;
        bus24.cfg_pulse_width = 16'd0;
        pulse_det24(1800);
        wait_cyc(1830);
        check("w0_n", rise24.size(), 1);
        check("w0_rise", rise24[0], 1812);
        check("w0_fall", fall24[0], 1813);

        // 8-bit timestamp: detect at ts=200, delay 100 -> due wraps, fires at ts=46
        clear_log();
        pulse_det8(1992);
        wait_cyc(2110);
        check("wrap_n", rise8.size(), 1);
        check("wrap_rise", rise8[0], 2094);
        check("wrap_rise_ts", rise8[0] % 256, 46);
        check("wrap_fall", fall8[0], 2098);
        check("wrap_late", bus8.late_sticky, 0);

        // 8-bit: cfg_delay 200 clamps to 127 -> 129-cycle latency
        clear_log();
        bus8.cfg_delay = 8'd200;
        pulse_det8(2200);
        wait_cyc(2350);
        check("clamp_n", rise8.size(), 1);
        check("clamp_rise", rise8[0], 2329);
        check("clamp_late", bus8.late_sticky, 0);

        // Reset asserted mid-FIRE drops eject_out without a clock edge
        bus24.cfg_delay = 24'd10;
        bus24.cfg_pulse_width = 16'd20;
        pulse_det24(2400);
        wait_cyc(2415);
        check("rstfire_pre", bus24.eject_out, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstfire_eject", bus24.eject_out, 0);
        check("rstfire_busy", bus24.busy, 0);
        check("rstfire_count", bus24.queue_count, 0);
        @(negedge clk_100m);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_100m);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sort_eject_scheduler.md
Name: sort_eject_scheduler

Overview:
Converts particle-detect pulses from the square-wave detector into timed ejector pulses for the sorting actuator. Each accepted detection is timestamped and queued with a due time of detect time plus the programmed conveyor delay. Queued events are fired in order as fixed-width pulses. The block sits between the squarewave/waveEnhance detection chain and the actuator/DAC marker output, and runs entirely in the clk_100m domain.

Parameters:
DELAY_W, 24, width of timestamp counter and cfg_delay
WIDTH_W, 16, width of cfg_pulse_width and cfg_holdoff
DEPTH, 8, pending-event FIFO depth (power of 2)

Ports:
clk_100m  in  1  system clock, 100 MHz
rst_n  in  1  reset
enable  in  1  1 = accept and fire events; 0 = flush queue and idle
det_in  in  1  detector level from squarewave stage, clk_100m-synchronous
cfg_delay  in  DELAY_W  detect-to-eject delay in cycles
cfg_pulse_width  in  WIDTH_W  eject pulse length in cycles
cfg_holdoff  in  WIDTH_W  cycles after an accepted event during which new edges are ignored
clr_sticky  in  1  clears overflow_sticky and late_sticky
eject_out  out  1  actuator drive, registered
busy  out  1  high when FSM is not IDLE or FIFO is non-empty
queue_count  out  $clog2(DEPTH)+1  FIFO occupancy
overflow_sticky  out  1  an event was dropped because the FIFO was full
late_sticky  out  1  an event fired after its due time

Behaviour:
- Reset is asynchronous, active-low (rst_n), on clock clk_100m. All outputs are 0; FIFO is empty; ts=0; FSM is IDLE; holdoff counter is 0.
- ts is a free-running DELAY_W counter that wraps mod 2^DELAY_W.
- Edge detect: event when det_in=1 and det_d=0 (det_d is a 1-cycle delayed copy).
- An event is accepted when enable=1 and the holdoff counter is 0.
- On acceptance, the holdoff counter loads cfg_holdoff and decrements to 0. Edges seen while it is non-zero are silently ignored.
- Accepted event pushes due = ts + eff_delay (mod 2^DELAY_W) on the next cycle.
- eff_delay = min(cfg_delay, 2^(DELAY_W-1)-1).
- If the FIFO is full, the push is dropped and overflow_sticky is set. Exception: a pop in the same cycle frees a slot, so the push succeeds.
- Simultaneous push and pop leaves queue_count unchanged.
- Due test is wrap-safe: reached = MSB of (ts - head_due) == 0.
- FSM:
  - IDLE: if FIFO is non-empty, go to WAIT.
  - WAIT: when reached, pop the head, load the width counter with max(cfg_pulse_width, 1), and go to FIRE. If reached is already true on the first WAIT cycle and ts != head_due, set late_sticky.
  - FIRE: eject_out=1; decrement the width counter; at 1, go to IDLE with eject_out=0 on the next cycle.
  - Back-to-back events are therefore separated by at least 2 low cycles (FIRE→IDLE→WAIT→FIRE). An event due during FIRE fires late, with late_sticky set.
- Latency: idle block, empty queue, det_in first sampled high at edge n → eject_out high from edge n+eff_delay+2 for exactly max(cfg_pulse_width, 1) cycles.
- Config inputs are sampled at use: delay at push, width at WAIT→FIRE, holdoff at acceptance. Changes do not affect queued entries.
- enable=0:
  - FIFO is flushed.
  - FSM goes to IDLE.
  - eject_out is 0 on the next edge.
  - Holdoff is cleared.
  - Sticky bits are held.
  - ts keeps running.
- clr_sticky has priority below a same-cycle set: the set wins.
- Reset mid-FIRE takes effect immediately: eject_out drops asynchronously.

Decomposition:
- Package sort_pkg:
  - FSM state enum {IDLE, WAIT, FIRE}
  - default DELAY_W/WIDTH_W/DEPTH constants
  - function due_reached(ts, due) implementing the MSB test
- Sub-module sort_event_fifo: synchronous FIFO, DEPTH x DELAY_W.
  - Ports: push, pop, din, dout (head, first-word-fall-through), full, empty, count, flush.
  - Pointer-plus-extra-bit full/empty.

Test Plan:
- Single event: cfg_delay=100, width=10, holdoff=0; det_in high at edge 50 → eject_out high at edges 152..161 only; late_sticky=0.
- Holdoff: holdoff=20; det_in rising edges at cycles 0, 10, 25 → 2 events queued (cycles 0 and 25), queue_count peaks at 2, 2 eject pulses spaced 25 cycles.
- Overflow: DEPTH=8, delay=1000, holdoff=0; 9 edges 4 cycles apart → queue_count=8, overflow_sticky=1, exactly 8 pulses; clr_sticky clears flag.
- Wrap: DELAY_W=8 build, delay=100; edges while ts=200 → fire at ts=46 (wrapped), correct 102-cycle latency; cfg_delay=200 is clamped to 127.
- Late fire: delay=50, width=30; edges 5 cycles apart → second pulse starts 2 cycles after first ends, late_sticky=1.
- Abort: enable low during FIRE with 3 queued → eject_out 0 next cycle, queue_count=0, busy=0; rst_n low mid-FIRE drops eject_out asynchronously.
